// File: rtl/dcfifo_s_pkg.sv
// Shared definitions for the dual-clock FIFO side logic.
//   RATIO_MAX : largest supported word-to-beat split factor.
//   ratio_f   : number of output beats that one FIFO word is split into.
//   idx_w_f   : width of a beat index for a given ratio (at least 1 bit).
package dcfifo_s_pkg;

    localparam int RATIO_MAX = 8;

    function automatic int ratio_f(input int width, input int out_width);
        return width / out_width;
    endfunction

    function automatic int idx_w_f(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/dcfifo_s_rd_unpacker.sv
// Read-side unpacker for a show-ahead dual-clock FIFO (rdclk domain).
// Pops one WIDTH-bit word from the FIFO head and replays it as RATIO
// OUT_WIDTH-bit beats on a valid/ready stream, flagging the final beat.
//
// Ports:
//   rdclk        - read-domain clock
//   aclr         - asynchronous active-high reset
//   fifo_q       - show-ahead FIFO head word (valid while fifo_rdempty=0)
//   fifo_rdempty - FIFO empty flag
//   fifo_rdreq   - pop request to the FIFO (combinational)
//   out_data     - current beat
//   out_valid    - beat valid
//   out_ready    - downstream accepts the beat
//   out_last     - current beat is the last slice of its word
//   out_idx      - slice index of the current beat
module dcfifo_s_rd_unpacker
    import dcfifo_s_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int OUT_WIDTH = 16,
    parameter bit LSB_FIRST = 1'b1,
    localparam int RATIO    = ratio_f(WIDTH, OUT_WIDTH),
    localparam int IDX_W    = idx_w_f(RATIO)
) (
    input  logic                 rdclk,
    input  logic                 aclr,
    input  logic [WIDTH-1:0]     fifo_q,
    input  logic                 fifo_rdempty,
    output logic                 fifo_rdreq,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [IDX_W-1:0]     out_idx
);

    generate
        if (RATIO < 2 || RATIO > RATIO_MAX || WIDTH != OUT_WIDTH * RATIO) begin : g_bad_ratio
            $error("dcfifo_s_rd_unpacker: WIDTH must be OUT_WIDTH*RATIO with RATIO in 2..%0d",
                   RATIO_MAX);
        end
    endgenerate

    logic [WIDTH-1:0] word_r;
    logic             valid_r;
    logic [IDX_W-1:0] idx_r;
    logic             last_c;
    logic             accept;
    logic             load;

    assign last_c    = valid_r && (idx_r == IDX_W'(RATIO - 1));
    assign accept    = valid_r && out_ready;
    // A new word is taken either when idle or in the same cycle the last
    // beat of the held word leaves, so consecutive words have no bubble.
    // Gated by aclr so no word is popped while the unpacker is held in reset.
    assign load      = !aclr && !fifo_rdempty && (!valid_r || (accept && last_c));

    assign fifo_rdreq = load;
    assign out_valid  = valid_r;
    assign out_idx    = idx_r;
    assign out_last   = last_c;

    // Slice select: index 0 is the low slice when LSB_FIRST, else the high slice.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (idx_r == IDX_W'(i)) begin
                out_data = word_r[(LSB_FIRST ? i : (RATIO - 1 - i)) * OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    // The held word is deliberately left out of reset; it is only
    // meaningful while valid_r is set.
    always_ff @(posedge rdclk or posedge aclr) begin
        if (aclr) begin
            valid_r <= 1'b0;
            idx_r   <= '0;
        end else begin
            if (load) begin
                word_r  <= fifo_q;
                valid_r <= 1'b1;
                idx_r   <= '0;
            end else if (accept) begin
                if (last_c) begin
                    valid_r <= 1'b0;
                    idx_r   <= '0;
                end else begin
                    idx_r <= idx_r + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dcfifo_s_rd_unpacker.sv
module tb_dcfifo_s_rd_unpacker;

    localparam int W     = 64;
    localparam int OW    = 16;
    localparam int RATIO = 4;

    logic          rdclk = 1'b0;
    logic          aclr;
    logic [W-1:0]  fifo_q;
    logic          fifo_rdempty;
    logic          out_ready;

    logic          l_rdreq, l_valid, l_last;
    logic [OW-1:0] l_data;
    logic [1:0]    l_idx;
    logic          m_rdreq, m_valid, m_last;
    logic [OW-1:0] m_data;
    logic [1:0]    m_idx;

    dcfifo_s_rd_unpacker #(.WIDTH(W), .OUT_WIDTH(OW), .LSB_FIRST(1'b1)) dut (
        .rdclk(rdclk), .aclr(aclr), .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty),
        .fifo_rdreq(l_rdreq), .out_data(l_data), .out_valid(l_valid),
        .out_ready(out_ready), .out_last(l_last), .out_idx(l_idx)
    );

    dcfifo_s_rd_unpacker #(.WIDTH(W), .OUT_WIDTH(OW), .LSB_FIRST(1'b0)) dut_msb (
        .rdclk(rdclk), .aclr(aclr), .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty),
        .fifo_rdreq(m_rdreq), .out_data(m_data), .out_valid(m_valid),
        .out_ready(out_ready), .out_last(m_last), .out_idx(m_idx)
    );

    always #5 rdclk = ~rdclk;

    typedef struct {
        logic [W-1:0] w;
        int           idx;
    } beat_t;

    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           rdreq_cnt = 0;
    logic [W-1:0] fifo_mem[$];
    beat_t        exp_beats[$];
    bit           hold     = 1'b0;
    bit           pop_req  = 1'b0;
    logic [OW-1:0] log_data[$];
    logic [OW-1:0] log_msb[$];
    bit            log_last[$];
    int            log_cyc[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic refresh();
        fifo_rdempty = hold || (fifo_mem.size() == 0);
        fifo_q       = (fifo_mem.size() != 0) ? fifo_mem[0] : 64'hDEAD_BEEF_0BAD_F00D;
    endtask

    function automatic logic [OW-1:0] slice_of(input logic [W-1:0] w, input int pos);
        logic [W-1:0] t;
        t = w >> (pos * OW);
        return t[OW-1:0];
    endfunction

    // Reference: a popped word turns into RATIO queued beats; the stream shows
    // the queue head; a pop is due when the FIFO has data and the queue is
    // empty or its final beat is being taken this cycle.
    task automatic compare_cycle();
        int    pend;
        bit    exp_rdreq;
        beat_t b;
        cyc++;
        if (aclr) begin
            chk("rst_valid", W'(l_valid), 0);
            chk("rst_rdreq", W'(l_rdreq), 0);
            chk("rst_idx",   W'(l_idx), 0);
            chk("rst_last",  W'(l_last), 0);
            chk("rst_valid_msb", W'(m_valid), 0);
            exp_beats.delete();
            pop_req = 1'b0;
            return;
        end
        pend      = exp_beats.size();
        exp_rdreq = !fifo_rdempty && (pend == 0 || (pend == 1 && out_ready));
        chk("rdreq",       W'(l_rdreq), W'(exp_rdreq));
        chk("rdreq_msb",   W'(m_rdreq), W'(exp_rdreq));
        chk("no_underflow", W'(l_rdreq & fifo_rdempty), 0);
        chk("valid",       W'(l_valid), W'(pend != 0));
        chk("valid_msb",   W'(m_valid), W'(pend != 0));
        if (pend != 0) begin
            b = exp_beats[0];
            chk("data",     W'(l_data), W'(slice_of(b.w, b.idx)));
            chk("idx",      W'(l_idx),  W'(b.idx));
            chk("last",     W'(l_last), W'(b.idx == RATIO - 1));
            chk("data_msb", W'(m_data), W'(slice_of(b.w, RATIO - 1 - b.idx)));
            chk("idx_msb",  W'(m_idx),  W'(b.idx));
            chk("last_msb", W'(m_last), W'(b.idx == RATIO - 1));
        end
        if (l_rdreq) rdreq_cnt++;
        if (l_valid && out_ready) begin
            log_data.push_back(l_data);
            log_msb.push_back(m_data);
            log_last.push_back(l_last);
            log_cyc.push_back(cyc);
            if (pend != 0) void'(exp_beats.pop_front());
        end
        if (l_rdreq && !fifo_rdempty) begin
            pop_req = 1'b1;
            for (int i = 0; i < RATIO; i++) exp_beats.push_back('{w: fifo_mem[0], idx: i});
        end
    endtask

    // One clock: compare mid-cycle, then apply the FIFO pop just after the edge.
    task automatic tick();
        @(negedge rdclk);
        compare_cycle();
        @(posedge rdclk);
        #1;
        if (pop_req) begin
            void'(fifo_mem.pop_front());
            pop_req = 1'b0;
        end
        refresh();
    endtask

    task automatic clear_log();
        log_data.delete(); log_msb.delete(); log_last.delete(); log_cyc.delete();
        rdreq_cnt = 0;
    endtask

    initial begin
        bit seen;
        aclr      = 1'b1;
        out_ready = 1'b0;
        refresh();
        repeat (3) tick();
        aclr = 1'b0;

        // Idle with empty FIFO
        repeat (10) tick();

        // Single word, continuous ready
        clear_log();
        out_ready = 1'b1;
        fifo_mem.push_back(64'h4444_3333_2222_1111);
        refresh();
        repeat (8) tick();
        chk("single_count", W'(log_data.size()), 4);
        chk("single_rdreq_pulses", W'(rdreq_cnt), 1);
        if (log_data.size() == 4) begin
            chk("single_b0", W'(log_data[0]), 64'h1111);
            chk("single_b1", W'(log_data[1]), 64'h2222);
            chk("single_b2", W'(log_data[2]), 64'h3333);
            chk("single_b3", W'(log_data[3]), 64'h4444);
            chk("single_last0", W'(log_last[0]), 0);
            chk("single_last3", W'(log_last[3]), 1);
            chk("msb_first", W'(log_msb[0]), 64'h4444);
            chk("msb_final", W'(log_msb[3]), 64'h1111);
            chk("single_span", W'(log_cyc[3] - log_cyc[0]), 3);
        end

        // Back-to-back words
        clear_log();
        fifo_mem.push_back(64'hA003_A002_A001_A000);
        fifo_mem.push_back(64'hB003_B002_B001_B000);
        fifo_mem.push_back(64'hC003_C002_C001_C000);
        refresh();
        repeat (16) tick();
        chk("b2b_count", W'(log_data.size()), 12);
        chk("b2b_pulses", W'(rdreq_cnt), 3);
        if (log_data.size() == 12) begin
            chk("b2b_span", W'(log_cyc[11] - log_cyc[0]), 11);
            chk("b2b_word2_first", W'(log_data[4]), 64'hB000);
            chk("b2b_word3_last", W'(log_data[11]), 64'hC003);
        end

        // Backpressure mid-word: ready 1,0,0,1
        clear_log();
        out_ready = 1'b0;
        fifo_mem.push_back(64'h8888_7777_6666_5555);
        refresh();
        tick();
        out_ready = 1'b1; tick();
        out_ready = 1'b0; tick();
        tick();
        out_ready = 1'b1;
        repeat (5) tick();
        chk("bp_count", W'(log_data.size()), 4);
        chk("bp_pulses", W'(rdreq_cnt), 1);
        if (log_data.size() == 4) begin
            chk("bp_b1", W'(log_data[1]), 64'h6666);
            chk("bp_b3", W'(log_data[3]), 64'h8888);
        end

        // Empty gap after last beat, word arrives 3 cycles later
        clear_log();
        fifo_mem.push_back(64'h0D0C_0B0A_0908_0706);
        refresh();
        repeat (6) tick();
        chk("gap_idle_valid", W'(l_valid), 0);
        repeat (2) tick();
        fifo_mem.push_back(64'h1D1C_1B1A_1918_1716);
        refresh();
        repeat (7) tick();
        chk("gap_count", W'(log_data.size()), 8);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            hold      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0 && fifo_mem.size() < 6)
                fifo_mem.push_back({$urandom, $urandom});
            refresh();
            tick();
        end
        hold      = 1'b0;
        out_ready = 1'b1;
        refresh();
        repeat (40) tick();

        // Reset mid-word
        clear_log();
        fifo_mem.push_back(64'h5555_6666_7777_8888);
        refresh();
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (log_data.size() >= 1) seen = 1'b1;
        end
        chk("rst_wait_beat", W'(seen), 1);
        #1 aclr = 1'b1;
        #1;
        chk("async_valid", W'(l_valid), 0);
        chk("async_idx",   W'(l_idx), 0);
        chk("async_rdreq", W'(l_rdreq), 0);
        repeat (2) tick();
        aclr = 1'b0;
        clear_log();
        fifo_mem.push_back(64'hF004_F003_F002_F001);
        refresh();
        repeat (8) tick();
        chk("post_rst_count", W'(log_data.size()), 4);
        if (log_data.size() >= 1)
            chk("post_rst_first", W'(log_data[0]), 64'hF001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcfifo_s_rd_unpacker.md
Name: dcfifo_s_rd_unpacker

Overview:
- Read-side consumer of a show-ahead dual-clock FIFO, in the rdclk domain.
- Pops one WIDTH-bit word from the FIFO head and emits it as RATIO = WIDTH/OUT_WIDTH narrower beats on a valid/ready stream.
- Flags the last beat of each word.
- Sits directly downstream of the show-ahead FIFO's q/rdempty/rdreq port; drives rdreq itself.

Parameters:
- WIDTH, 64, FIFO word width; must equal OUT_WIDTH*RATIO.
- OUT_WIDTH, 16, output beat width; RATIO must be 2..8, elaboration $error otherwise.
- LSB_FIRST, 1, 1: beat 0 = word[OUT_WIDTH-1:0]; 0: beat 0 = most-significant slice.

Ports:
- rdclk  in  1  clock.
- aclr  in  1  asynchronous active-high reset.
- fifo_q  in  WIDTH  show-ahead FIFO head data; valid when fifo_rdempty=0.
- fifo_rdempty  in  1  FIFO empty.
- fifo_rdreq  out  1  pop FIFO head this cycle.
- out_data  out  OUT_WIDTH  current beat.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts beat.
- out_last  out  1  current beat is the final slice of its word.
- out_idx  out  $clog2(RATIO)  slice index of current beat (0..RATIO-1).

Behaviour:
- Reset: aclr is asynchronous, active-high; clock is rdclk. During aclr: out_valid=0, out_idx=0, out_last=0, fifo_rdreq=0. Held word register is not reset.
- State: word_r (WIDTH), valid_r, idx_r. out_valid=valid_r, out_idx=idx_r. out_last=valid_r && idx_r==RATIO-1.
- out_data: slice idx_r of word_r per LSB_FIRST. Mux is combinational from registers only.
- accept = out_valid && out_ready.
- load = !fifo_rdempty && (!valid_r || (accept && out_last)).
- fifo_rdreq = load, combinational. Never asserted while fifo_rdempty=1 (no underflow). Path from out_ready to fifo_rdreq is permitted.
- On load: word_r<=fifo_q, valid_r<=1, idx_r<=0.
- On accept without out_last: idx_r<=idx_r+1.
- On accept with out_last and no load: valid_r<=0, idx_r<=0.
- Latency: word at FIFO head while idle -> out_valid=1 on next rdclk edge.
- Throughput: one beat per cycle with out_ready=1. No bubble between consecutive words when the FIFO is non-empty (last-beat accept and load occur in the same cycle).
- Backpressure: out_ready=0 holds out_data/out_idx/out_last stable and keeps fifo_rdreq=0.
- Valid rule: out_valid, once asserted, is not withdrawn until accepted.
- FIFO empty at last-beat accept: valid_r drops. Next word loads when fifo_rdempty falls.
- fifo_q is sampled only in the load cycle; later changes to fifo_q are ignored.
- Reset mid-word: partial word discarded. Remaining beats are not emitted; the FIFO word is already consumed.
- idx_r wraps only via load/last; never exceeds RATIO-1.

Decomposition:
- Shared package dcfifo_s_pkg: function ratio_f(WIDTH,OUT_WIDTH), constant RATIO_MAX=8, function idx_w_f(ratio) returning max(1,$clog2(ratio)).
- No sub-module. Single module with one always_ff (async aclr) and combinational slice mux/load logic.

Test Plan:
- Reset/idle: aclr=1 then 0, fifo_rdempty=1 for 10 cycles -> out_valid=0, fifo_rdreq=0 every cycle.
- Single word, LSB_FIRST=1, default widths: fifo_q=64'h4444_3333_2222_1111, out_ready=1. Expect:
  - fifo_rdreq=1 for exactly one cycle.
  - Beats 1111,2222,3333,4444 on consecutive cycles, out_idx 0..3.
  - out_last only on 4444.
- Back-to-back: 3 words queued, out_ready=1 -> 12 beats in 12 consecutive cycles. Each fifo_rdreq pulse coincides with the out_last accept of the prior word (except the first).
- Backpressure: out_ready toggled 1,0,0,1 mid-word -> beat held and idx frozen during ready=0; no extra fifo_rdreq; data order unchanged. LSB_FIRST=0 run gives 4444 first.
- Empty gap: fifo_rdempty=1 when last beat is accepted -> out_valid=0 next cycle. Word arriving 3 cycles later -> out_valid=1 one cycle after fifo_rdempty falls.
- Reset mid-word: assert aclr after beat 1 -> out_valid=0 immediately (asynchronous). After release, the next FIFO word starts at out_idx=0.
